// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with multi-cycle shift and shift-and-add multiply
//
// Purpose: latches an opcode and two operands on start, runs single-cycle ops
// in one EXEC cycle, shifts one bit per cycle for SHL/SHR and runs a WIDTH-cycle
// shift-and-add multiply. The result and flags are registered, published with a
// one-cycle done pulse, and held until the next done.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   begin an operation (accepted in IDLE or DONE)
//   alu_op   in   [3:0] opcode
//   inA      in   [WIDTH-1:0] operand A (accumulator side)
//   inB      in   [WIDTH-1:0] operand B (memory side)
//   busy     out  high while an operation is executing
//   done     out  one-cycle pulse, result valid
//   alu_out  out  [WIDTH-1:0] registered result
//   zero     out  registered skip-if-zero flag
//   carry    out  registered carry/borrow/overflow flag

module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_LDA = 4'b0101;
    localparam logic [3:0] OP_STO = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1001;
    localparam logic [3:0] OP_SHR = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_lo;   // shift work register, or multiplier/low product
    logic [WIDTH-1:0] r_hi;   // high half of the product
    logic [CW-1:0]    r_cnt;  // remaining EXEC cycles for shift/multiply

    logic [CW-1:0]    w_k;
    logic             w_fin;
    logic [WIDTH-1:0] w_fin_res;
    logic             w_fin_c;
    logic             w_zero;
    logic             w_zero_from_a;
    logic [WIDTH-1:0] w_shift_val;
    logic             w_shift_bit;
    logic [WIDTH:0]   w_madd;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // Shift count saturates at WIDTH: shifting further changes nothing.
    assign w_k = (inB > WIDTH'(WIDTH)) ? CW'(WIDTH) : CW'(inB);

    // Opcodes 000x and 011x report whether the accumulator operand was zero.
    assign w_zero_from_a = (r_op[3:1] == 3'b000) || (r_op[3:1] == 3'b011);
    assign w_zero        = w_zero_from_a ? (r_a == '0) : (w_fin_res == '0);

    always_comb begin
        w_fin       = 1'b0;
        w_fin_res   = r_a;
        w_fin_c     = 1'b0;
        w_shift_val = r_lo;
        w_shift_bit = 1'b0;
        w_madd      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
        w_hi_nxt    = w_madd[WIDTH:1];
        w_lo_nxt    = {w_madd[0], r_lo[WIDTH-1:1]};
        case (r_op)
            OP_SHL, OP_SHR: begin
                if (r_op == OP_SHL) begin
                    w_shift_val = {r_lo[WIDTH-2:0], 1'b0};
                    w_shift_bit = r_lo[WIDTH-1];
                end else begin
                    w_shift_val = {1'b0, r_lo[WIDTH-1:1]};
                    w_shift_bit = r_lo[0];
                end
                if (r_cnt == '0) begin
                    // k=0: one EXEC cycle, A unchanged, nothing shifted out
                    w_fin     = 1'b1;
                    w_fin_res = r_a;
                    w_fin_c   = 1'b0;
                end else if (r_cnt == CW'(1)) begin
                    w_fin     = 1'b1;
                    w_fin_res = w_shift_val;
                    w_fin_c   = w_shift_bit;
                end
            end
            OP_MUL: begin
                // Low product half ends up in r_lo after WIDTH right shifts.
                w_fin     = (r_cnt == CW'(1));
                w_fin_res = w_lo_nxt;
                w_fin_c   = |w_hi_nxt;
            end
            OP_ADD: begin
                w_fin = 1'b1;
                {w_fin_c, w_fin_res} = {1'b0, r_a} + {1'b0, r_b};
            end
            OP_SUB: begin
                w_fin     = 1'b1;
                w_fin_res = r_a - r_b;
                w_fin_c   = (r_a < r_b);
            end
            OP_AND: begin
                w_fin     = 1'b1;
                w_fin_res = r_a & r_b;
            end
            OP_XOR: begin
                w_fin     = 1'b1;
                w_fin_res = r_a ^ r_b;
            end
            OP_LDA: begin
                w_fin     = 1'b1;
                w_fin_res = r_b;
            end
            OP_STO: begin
                w_fin     = 1'b1;
                w_fin_res = r_a;
            end
            default: begin
                w_fin     = 1'b1;
                w_fin_res = r_a;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_out <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_op    <= alu_op;
                        r_a     <= inA;
                        r_b     <= inB;
                        r_lo    <= (alu_op == OP_MUL) ? inB : inA;
                        r_hi    <= '0;
                        r_cnt   <= (alu_op == OP_MUL) ? CW'(WIDTH) : w_k;
                        busy    <= 1'b1;
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    if (w_fin) begin
                        alu_out <= w_fin_res;
                        carry   <= w_fin_c;
                        zero    <= w_zero;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                        r_lo  <= (r_op == OP_MUL) ? w_lo_nxt : w_shift_val;
                        r_hi  <= w_hi_nxt;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq (WIDTH=8)

module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] alu_op;
    logic [7:0] inA;
    logic [7:0] inB;
    logic       busy;
    logic       done;
    logic [7:0] alu_out;
    logic       zero;
    logic       carry;

    alu_seq #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .alu_op  (alu_op),
        .inA     (inA),
        .inB     (inB),
        .busy    (busy),
        .done    (done),
        .alu_out (alu_out),
        .zero    (zero),
        .carry   (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       c;
        int         lat;
        int         t0;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [15:0] t;
        logic [8:0]  s;
        int k;
        k = (b > 8) ? 8 : int'(b);
        e.c   = 1'b0;
        e.res = a;
        e.lat = 2;
        e.t0  = 0;
        case (op)
            4'b0010: begin s = {1'b0, a} + {1'b0, b}; e.res = s[7:0]; e.c = s[8]; end
            4'b0011: e.res = a & b;
            4'b0100: e.res = a ^ b;
            4'b0101: e.res = b;
            4'b0110: e.res = a;
            4'b1000: begin e.res = a - b; e.c = (a < b); end
            4'b1001: begin
                t = {8'h00, a} << k;
                e.res = t[7:0];
                e.c   = (k != 0) ? t[8] : 1'b0;
                e.lat = 1 + ((k > 1) ? k : 1);
            end
            4'b1010: begin
                t = {a, 8'h00} >> k;
                e.res = t[15:8];
                e.c   = (k != 0) ? t[7] : 1'b0;
                e.lat = 1 + ((k > 1) ? k : 1);
            end
            4'b1011: begin
                t = 16'(a) * 16'(b);
                e.res = t[7:0];
                e.c   = |t[15:8];
                e.lat = 9;
            end
            default: e.res = a;
        endcase
        if (op == 4'b0000 || op == 4'b0001 || op == 4'b0110 || op == 4'b0111)
            e.z = (a == 8'h00);
        else
            e.z = (e.res == 8'h00);
        return e;
    endfunction

    // Called at a negedge: drives one start pulse and records the expectation.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e    = model(op, a, b);
        e.t0 = cyc;
        sb.push_back(e);
        alu_op = op;
        inA    = a;
        inB    = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        check("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("alu_out", alu_out, e.res);
                check("zero", zero, e.z);
                check("carry", carry, e.c);
                check("latency", cyc - e.t0, e.lat);
                check("busy_at_done", busy, 0);
            end
        end
    end

    initial begin
        int w;
        rst_n  = 1'b0;
        start  = 1'b1;
        alu_op = 4'b0010;
        inA    = 8'hFF;
        inB    = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_alu_out", alu_out, 0);
        check("rst_zero", zero, 0);
        check("rst_carry", carry, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        issue(4'b0010, 8'hF0, 8'h20);
        check("busy_rises", busy, 1);
        drain();

        // back-to-back: second SUB issued on the cycle done is high
        issue(4'b1000, 8'h05, 8'h05);
        w = 0;
        while (!done && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("b2b_done_seen", done, 1);
        issue(4'b1000, 8'h03, 8'h05);
        drain();

        issue(4'b1001, 8'h81, 8'h03); drain();
        issue(4'b1010, 8'h81, 8'h00); drain();
        issue(4'b1010, 8'h81, 8'h0C); drain();
        issue(4'b1011, 8'h0D, 8'h0B); drain();
        issue(4'b1011, 8'h14, 8'h14); drain();
        issue(4'b0110, 8'h00, 8'hFF); drain();
        issue(4'b0000, 8'h07, 8'h00); drain();

        // start pulsed mid-MUL must be ignored
        issue(4'b1011, 8'h0D, 8'h0B);
        @(negedge clk);
        alu_op = 4'b0010;
        inA    = 8'hFF;
        inB    = 8'hFF;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        // reset sampled on the 4th edge of a MUL aborts it without a done
        alu_op = 4'b1011;
        inA    = 8'h0D;
        inB    = 8'h0B;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_alu_out", alu_out, 0);
        check("abort_done", done, 0);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            logic [3:0] op;
            logic [7:0] a;
            logic [7:0] b;
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            issue(op, a, b);
            drain();
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
